// File: rtl/mod_counter.sv
// Parametrised up/down modulus counter with load, wrap/saturate mode, terminal-count pulse and sticky overflow.
// Optional clock-enable prescaler compiled in with `define MOD_COUNTER_PRESCALER_EN.
module mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    // Elaboration-time parameter sanity
    if (WIDTH < 2) begin : g_bad_width
        $error("mod_counter: WIDTH must be >= 2");
    end
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("mod_counter: PRESCALE must be >= 2");
    end

    logic             tick;
    logic             boundary;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

`ifdef MOD_COUNTER_PRESCALER_EN
    localparam int unsigned PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0] PH_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;

    assign tick = (phase == PH_LAST);

    // Phase restarts on load, advances only while enabled
    always_comb begin
        phase_nxt = phase;
        if (load) begin
            phase_nxt = '0;
        end else if (en) begin
            phase_nxt = tick ? '0 : phase + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else begin
            phase <= phase_nxt;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Boundary is detected before stepping so the count never leaves 0..MODULUS-1
    always_comb begin
        count_nxt = count;
        boundary  = 1'b0;
        if (load) begin
            count_nxt = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
        end else if (en && tick) begin
            if (up) begin
                if (count == MAX_VAL) begin
                    boundary  = 1'b1;
                    count_nxt = sat ? count : '0;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    boundary  = 1'b1;
                    count_nxt = sat ? count : MAX_VAL;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
        tc_nxt  = boundary;
        ovf_nxt = boundary | (ovf & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=4, MODULUS=10): directed vector table plus randomized model check.
module tb_mod_counter;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned MODULUS  = 10;
    localparam int unsigned PRESCALE = 4;

    logic             clk = 1'b0;
    logic             rst, en, up, sat, load, ovf_clr;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc, ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(count), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, en, up, sat, load;
        int load_val;
        bit clr;
        int exp_cnt;
        bit exp_tc, exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit e, bit u, bit s, bit l, int lv, bit c,
                                int ec, bit et, bit eo);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.sat = s; v.load = l; v.load_val = lv; v.clr = c;
        v.exp_cnt = ec; v.exp_tc = et; v.exp_ovf = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int ec, bit et, bit eo);
        n_cmp++;
        if (int'(count) != ec || tc !== et || ovf !== eo) begin
            n_fail++;
            $display("FAIL %s: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                     name, count, tc, ovf, ec, et, eo);
        end
    endtask

    task automatic drive(bit r, bit e, bit u, bit s, bit l, int lv, bit c);
        rst = r; en = e; up = u; sat = s; load = l; load_val = WIDTH'(lv); ovf_clr = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: plain integers following the counting rules
    int m_cnt, m_phase;
    bit m_tc, m_ovf;

    task automatic model_step(bit r, bit e, bit u, bit s, bit l, int lv, bit c);
        bit hit;
        bit do_step;
        hit = 0;
        if (r) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_phase = 0;
            return;
        end
        do_step = 0;
        if (l) begin
            m_cnt   = (lv > MODULUS - 1) ? MODULUS - 1 : lv;
            m_phase = 0;
        end else if (e) begin
`ifdef MOD_COUNTER_PRESCALER_EN
            m_phase = m_phase + 1;
            if (m_phase == PRESCALE) begin
                m_phase = 0;
                do_step = 1;
            end
`else
            do_step = 1;
`endif
        end
        if (do_step) begin
            int t;
            t = u ? m_cnt + 1 : m_cnt - 1;
            if (t < 0 || t >= int'(MODULUS)) begin
                hit = 1;
                if (!s) t = (t < 0) ? MODULUS - 1 : 0;
                else    t = m_cnt;
            end
            m_cnt = t;
        end
        m_tc  = hit;
        m_ovf = hit || (m_ovf && !c);
    endtask

    initial begin
        rst = 1; en = 0; up = 0; sat = 0; load = 0; load_val = '0; ovf_clr = 0;

`ifndef MOD_COUNTER_PRESCALER_EN
        // reset with en and load active
        add(1,1,1,0,1,5,0, 0,0,0);
        add(1,1,1,0,1,5,0, 0,0,0);
        // count up, wrap after 9
        for (int i = 1; i <= 9; i++) add(0,1,1,0,0,0,0, i,0,0);
        add(0,1,1,0,0,0,0, 0,1,1);
        add(0,1,1,0,0,0,0, 1,0,1);
        add(0,1,1,0,0,0,0, 2,0,1);
        add(0,0,1,0,0,0,1, 2,0,0);
        // load 2 then count down saturating
        add(0,0,0,0,1,2,0, 2,0,0);
        add(0,1,0,1,0,0,0, 1,0,0);
        add(0,1,0,1,0,0,0, 0,0,0);
        add(0,1,0,1,0,0,0, 0,1,1);
        add(0,1,0,1,0,0,0, 0,1,1);
        add(0,1,0,1,0,0,0, 0,1,1);
        // set/clear race then clear alone
        add(0,1,0,1,0,0,1, 0,1,1);
        add(0,0,0,1,0,0,1, 0,0,0);
        // load beats pending boundary step, clamps, and ovf_clr still clears
        add(0,1,0,1,0,0,0, 0,1,1);
        add(0,1,0,1,1,15,1, 9,0,0);
        add(0,1,1,0,1,15,0, 9,0,0);
        // saturate up at top, then en low holds count and ovf
        add(0,1,1,1,0,0,0, 9,1,1);
        add(0,0,1,1,0,0,0, 9,0,1);
        // down-wrap from 0 to 9
        add(0,0,0,0,1,0,1, 0,0,0);
        add(0,1,0,0,0,0,0, 9,1,1);
        add(0,1,0,0,0,0,0, 8,0,1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].load,
                  vecs[i].load_val, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_tc, vecs[i].exp_ovf);
        end
`else
        // prescaler: one step per PRESCALE enabled cycles, phase holds while en=0
        drive(1,0,1,0,0,0,0);
        check("pre_rst", 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(0,1,1,0,0,0,0);
            check($sformatf("pre_c%0d", i), i / 4, 0, 0);
        end
        drive(0,1,1,0,0,0,0);
        drive(0,1,1,0,0,0,0);
        check("pre_mid", 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0,0,1,0,0,0,0);
            check($sformatf("pre_hold%0d", i), 2, 0, 0);
        end
        drive(0,1,1,0,0,0,0);
        check("pre_res1", 2, 0, 0);
        drive(0,1,1,0,0,0,0);
        check("pre_res2", 3, 0, 0);
        drive(0,1,1,0,1,7,0);
        check("pre_load", 7, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(0,1,1,0,0,0,0);
            check($sformatf("pre_ld%0d", i), (i == 4) ? 8 : 7, 0, 0);
        end
`endif

        // randomized run against the reference model
        for (int i = 0; i < 600; i++) begin
            bit r, e, u, s, l, c;
            int lv;
            r  = (i == 0) || ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 9) < 8);
            u  = ($urandom_range(0, 3) != 0) ^ (i[7]);
            s  = $urandom_range(0, 1) != 0;
            l  = ($urandom_range(0, 11) == 0);
            c  = ($urandom_range(0, 9) == 0);
            lv = $urandom_range(0, 15);
            model_step(r, e, u, s, l, lv, c);
            drive(r, e, u, s, l, lv, c);
            check($sformatf("rnd%0d", i), m_cnt, m_tc, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulus counter: the next-generation replacement for the fixed 4-bit enable counter in the digital examples. It adds configurable width and modulus, direction control, parallel load, and a wrap-or-saturate mode. It also provides a registered terminal-count pulse and a sticky overflow flag. It is used standalone as a timebase/event counter, or as a building block in larger example designs.

## Interface
Parameters:
- WIDTH, 8, count width in bits; ≥ 2.
- MODULUS, 256, count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- PRESCALE, 4, clock-enable divider ratio; ≥ 2; used only with MOD_COUNTER_PRESCALER_EN.

Ports:
- clk  in  1  clock; one clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  boundary mode: 0 = wrap, 1 = saturate.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  load value.
- ovf_clr  in  1  clears sticky overflow flag.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky boundary-hit flag, registered.

## Operation
- Priority per cycle: rst > load > step > hold.
- rst: count=0, tc=0, ovf=0, prescaler=0. Reset mid-count discards everything, including a same-cycle load or en.
- load: count = min(load_val, MODULUS-1) (values ≥ MODULUS clamp). Prescaler phase reset to 0. No tc/ovf event.
- step: occurs when en=1 (and prescaler tick, if compiled in). Up: count+1. Down: count-1.
- Boundary event: step with up=1 at count=MODULUS-1, or up=0 at count=0.
  - sat=0: wrap to 0 (up) or MODULUS-1 (down).
  - sat=1: count holds at the boundary.
  - Either mode: tc=1 for the next cycle; ovf set.
  - Saturated and still enabled: tc re-pulses on every further step (level-high while stuck).
- tc=0 on every cycle without a boundary event.
- ovf: set by a boundary event, cleared by ovf_clr. Simultaneous set and clear: set wins.
- en=0: count, tc=0, ovf, and prescaler phase all hold.
- up and sat may change on any cycle. They take effect at the next step.
- Arithmetic is unsigned. Intermediate values never exceed WIDTH bits because boundary detection precedes increment/decrement.

## Timing
- Latency: inputs sampled at edge N; count/tc/ovf reflect them after edge N (visible in cycle N+1).
- tc is asserted in the same cycle count shows the wrapped or held value.
- All outputs are registered; no combinational input-to-output path.
- Reset values: count=0, tc=0, ovf=0.
- Without the prescaler: one step per enabled cycle.
- With the prescaler: one step per PRESCALE enabled cycles, on the PRESCALE-th enabled cycle after reset/load.

## Configuration
- Macro: MOD_COUNTER_PRESCALER_EN.
- Defined:
  - Internal $clog2(PRESCALE)-bit phase counter advances while en=1.
  - A step occurs only when phase=PRESCALE-1, after which phase returns to 0.
  - Phase clears on rst and load; it holds when en=0.
- Undefined: no phase counter; step = en. The PRESCALE parameter is ignored.

## Test plan
(WIDTH=4, MODULUS=10, prescaler off unless noted)
- Reset: rst=1 for 2 cycles with en=1, load=1 -> count=0, tc=0, ovf=0 throughout and after release.
- Up, wrap: sat=0, up=1, en=1 from 0 for 12 cycles -> counts 1..9, 0, 1, 2; tc=1 only in the cycle count=0; ovf=1 from then on.
- Down, saturate: load_val=2, then sat=1, up=0, en=1 for 5 cycles -> count 1, 0, 0, 0, 0; tc=1 on each of the three held cycles; ovf=1.
- Load clamp and priority: load=1, load_val=15, en=1 -> count=9, tc=0. Same cycle as ovf_clr with a boundary step pending -> load wins, ovf cleared.
- ovf set/clear race: boundary step and ovf_clr in the same cycle -> ovf=1. Next cycle, ovf_clr alone -> ovf=0.
- Prescaler (macro defined, PRESCALE=4): en=1 for 8 cycles from 0 -> count 1 after cycle 4, 2 after cycle 8. Drop en for 3 cycles mid-phase -> phase and count hold, then resume correctly.
